// File: rtl/spi_dev_mem.sv
// SPI mode-0 target with a byte-addressed memory, oversampled in the clk_i domain.
// Commands: 0x02 write burst, 0x03 read burst, 0x9F ID; anything else is ignored and flagged.
module spi_dev_mem #(
    parameter int unsigned Depth      = 256,
    parameter int unsigned AddrWidth  = $clog2(Depth),
    parameter int unsigned SyncStages = 2,
    parameter logic [7:0]  IdByte     = 8'hC5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 spi_sck_i,
    input  logic                 spi_csb_i,
    input  logic                 spi_sd_i,
    output logic                 spi_sd_o,
    output logic                 spi_sd_en_o,
    input  logic [AddrWidth-1:0] bd_addr_i,
    output logic [7:0]           bd_rdata_o,
    output logic                 busy_o,
    output logic                 cmd_done_o,
    output logic                 err_o,
    output logic [15:0]          wr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_ID,
        S_IGNORE
    } state_e;

    logic [SyncStages-1:0] sck_sync_q, csb_sync_q, sd_sync_q;
    logic                  sck_prev_q, csb_prev_q, busy_q;
    logic                  sck_s, csb_s, sd_s;
    logic                  sck_rise, sck_fall, csb_rise, csb_fall;

    state_e                state_q;
    logic [2:0]            bit_cnt_q;
    logic [6:0]            shin_q;
    logic [7:0]            shout_q;
    logic [AddrWidth-1:0]  addr_q;
    logic                  is_wr_q, cmd_ok_q, cmd_bad_q;
    logic                  sd_o_q, sd_en_q, cmd_done_q, err_q;
    logic [15:0]           wr_count_q;
    logic [7:0]            mem_q [Depth];

    logic [7:0]            rx_byte_d;
    logic [AddrWidth-1:0]  addr_inc_d;

    // Pin synchronizers; CSB idles high so its chain resets to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0;
            csb_sync_q <= '1;
            sd_sync_q  <= '0;
        end else begin
            sck_sync_q[0] <= spi_sck_i;
            csb_sync_q[0] <= spi_csb_i;
            sd_sync_q[0]  <= spi_sd_i;
            for (int i = 1; i < int'(SyncStages); i++) begin
                sck_sync_q[i] <= sck_sync_q[i-1];
                csb_sync_q[i] <= csb_sync_q[i-1];
                sd_sync_q[i]  <= sd_sync_q[i-1];
            end
        end
    end

    assign sck_s = sck_sync_q[SyncStages-1];
    assign csb_s = csb_sync_q[SyncStages-1];
    assign sd_s  = sd_sync_q[SyncStages-1];

    // Edge-detect registers on the synchronized pins, plus the busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_prev_q <= 1'b0;
            csb_prev_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            csb_prev_q <= csb_s;
            busy_q     <= ~csb_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csb_rise = csb_s & ~csb_prev_q;
    assign csb_fall = ~csb_s & csb_prev_q;

    assign rx_byte_d  = {shin_q, sd_s};
    assign addr_inc_d = addr_q + AddrWidth'(1);

    // Protocol FSM with shift registers, memory and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shin_q     <= 7'd0;
            shout_q    <= 8'd0;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_bad_q  <= 1'b0;
            sd_o_q     <= 1'b0;
            sd_en_q    <= 1'b0;
            cmd_done_q <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= 16'd0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            cmd_done_q <= 1'b0;
            err_q      <= 1'b0;
            if (csb_rise) begin
                // End of transaction: any partial byte is simply dropped.
                state_q    <= S_IDLE;
                sd_o_q     <= 1'b0;
                sd_en_q    <= 1'b0;
                cmd_done_q <= cmd_ok_q;
                err_q      <= cmd_bad_q;
                cmd_ok_q   <= 1'b0;
                cmd_bad_q  <= 1'b0;
            end else if (csb_fall) begin
                // Start (or restart after a glitch) at the command byte.
                state_q   <= S_CMD;
                bit_cnt_q <= 3'd0;
                sd_o_q    <= 1'b0;
                sd_en_q   <= 1'b0;
                is_wr_q   <= 1'b0;
                cmd_ok_q  <= 1'b0;
                cmd_bad_q <= 1'b0;
            end else if (state_q != S_IDLE) begin
                if (sck_rise) begin
                    shin_q    <= rx_byte_d[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        unique case (state_q)
                            S_CMD: begin
                                unique case (rx_byte_d)
                                    8'h02: begin
                                        state_q  <= S_ADDR;
                                        is_wr_q  <= 1'b1;
                                        cmd_ok_q <= 1'b1;
                                    end
                                    8'h03: begin
                                        state_q  <= S_ADDR;
                                        is_wr_q  <= 1'b0;
                                        cmd_ok_q <= 1'b1;
                                    end
                                    8'h9F: begin
                                        state_q  <= S_ID;
                                        shout_q  <= IdByte;
                                        cmd_ok_q <= 1'b1;
                                    end
                                    default: begin
                                        state_q   <= S_IGNORE;
                                        cmd_bad_q <= 1'b1;
                                    end
                                endcase
                            end
                            S_ADDR: begin
                                addr_q <= rx_byte_d[AddrWidth-1:0];
                                if (is_wr_q) begin
                                    state_q <= S_WDATA;
                                end else begin
                                    state_q <= S_RDATA;
                                    shout_q <= mem_q[rx_byte_d[AddrWidth-1:0]];
                                end
                            end
                            S_WDATA: begin
                                mem_q[addr_q] <= rx_byte_d;
                                addr_q        <= addr_inc_d;
                                if (wr_count_q != 16'hFFFF) begin
                                    wr_count_q <= wr_count_q + 16'd1;
                                end
                            end
                            S_RDATA: begin
                                shout_q <= mem_q[addr_inc_d];
                                addr_q  <= addr_inc_d;
                            end
                            S_ID: begin
                                shout_q <= IdByte;
                            end
                            default: begin
                            end
                        endcase
                    end
                end else if (sck_fall && (state_q == S_RDATA || state_q == S_ID)) begin
                    // Drive the next MISO bit; enable turns on with the first one.
                    sd_o_q  <= shout_q[7];
                    shout_q <= {shout_q[6:0], 1'b0};
                    sd_en_q <= 1'b1;
                end
            end
        end
    end

    assign spi_sd_o    = sd_o_q;
    assign spi_sd_en_o = sd_en_q;
    assign busy_o      = busy_q;
    assign cmd_done_o  = cmd_done_q;
    assign err_o       = err_q;
    assign wr_count_o  = wr_count_q;
    assign bd_rdata_o  = mem_q[bd_addr_i];

endmodule

// File: tb/tb_spi_dev_mem.sv
// Bench for spi_dev_mem: vector table of SPI transactions, hand-written corner
// sequences and a randomized burst run against a reference memory model.
module tb_spi_dev_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       csb = 1'b1;
    logic       mosi = 1'b0;
    logic       spi_sd_o, spi_sd_en_o;
    logic [7:0] bd_addr = 8'd0;
    logic [7:0] bd_rdata;
    logic       busy_o, cmd_done_o, err_o;
    logic [15:0] wr_count_o;

    spi_dev_mem dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .spi_sck_i   (sck),
        .spi_csb_i   (csb),
        .spi_sd_i    (mosi),
        .spi_sd_o    (spi_sd_o),
        .spi_sd_en_o (spi_sd_en_o),
        .bd_addr_i   (bd_addr),
        .bd_rdata_o  (bd_rdata),
        .busy_o      (busy_o),
        .cmd_done_o  (cmd_done_o),
        .err_o       (err_o),
        .wr_count_o  (wr_count_o)
    );

    always #5 clk = ~clk;

    // Pulse and enable monitors (cumulative, read as deltas by the test).
    int done_total = 0;
    int err_total  = 0;
    int en_total   = 0;
    always @(negedge clk) begin
        if (cmd_done_o)  done_total++;
        if (err_o)       err_total++;
        if (spi_sd_en_o) en_total++;
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] model_mem [256];
    int         model_cnt;
    logic [7:0] sb_q [$];
    logic       en_last;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        int          n;
        logic [23:0] wd;
        logic [23:0] ex;
        int          exp_done;
        int          exp_err;
        int          exp_en;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 host: MOSI set while SCK low, MISO captured just before the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wclk(4);
            rx = {rx[6:0], spi_sd_o};
            sck = 1'b1;
            wclk(4);
            sck = 1'b0;
        end
    endtask

    task automatic cs_start();
        csb = 1'b0;
        wclk(4);
    endtask

    task automatic cs_end();
        wclk(4);
        en_last = spi_sd_en_o;
        csb = 1'b1;
        wclk(8);
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
        bd_addr = a;
        #1;
        d = bd_rdata;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'd0;
        model_cnt = 0;
    endtask

    // Full transaction; writes update the model, reads go through the scoreboard.
    task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                       input logic [23:0] wd, input logic [23:0] ex);
        logic [7:0] rx, e, b;
        cs_start();
        spi_bits(cmd, 8, rx);
        if (cmd == 8'h02 || cmd == 8'h03) spi_bits(addr, 8, rx);
        for (int i = 0; i < n; i++) begin
            if (cmd == 8'h02) begin
                b = wd[23-8*i -: 8];
                spi_bits(b, 8, rx);
                model_mem[8'(addr + 8'(i))] = b;
                model_cnt++;
            end else begin
                sb_q.push_back(ex[23-8*i -: 8]);
                spi_bits(8'h00, 8, rx);
                e = sb_q.pop_front();
                check("miso_byte", 32'(rx), 32'(e));
            end
        end
        cs_end();
    endtask

    initial begin
        logic [7:0]  d, rx, a, b0, b1;
        int          d0, e0, n0;

        vecs[0] = '{8'h02, 8'h10, 2, 24'hAA5500, 24'h000000, 1, 0, 0};
        vecs[1] = '{8'h03, 8'h10, 2, 24'h000000, 24'hAA5500, 1, 0, 1};
        vecs[2] = '{8'h02, 8'hFF, 2, 24'h112200, 24'h000000, 1, 0, 0};
        vecs[3] = '{8'h03, 8'hFF, 2, 24'h000000, 24'h112200, 1, 0, 1};
        vecs[4] = '{8'h9F, 8'h00, 3, 24'h000000, 24'hC5C5C5, 1, 0, 1};
        vecs[5] = '{8'h77, 8'h00, 1, 24'h000000, 24'h000000, 0, 1, 0};
        model_clear();

        // Reset state
        wclk(3);
        check("rst_sd_o", 32'(spi_sd_o), 0);
        check("rst_sd_en", 32'(spi_sd_en_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(cmd_done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_wr_count", 32'(wr_count_o), 0);
        bd_read(8'h00, d);
        check("rst_mem", 32'(d), 0);
        rst_n = 1'b1;
        wclk(6);
        check("idle_busy", 32'(busy_o), 0);

        // Vector table
        for (int v = 0; v < 6; v++) begin
            d0 = done_total; e0 = err_total; n0 = en_total;
            txn(vecs[v].cmd, vecs[v].addr, vecs[v].n, vecs[v].wd, vecs[v].ex);
            check("vec_done_pulses", 32'(done_total - d0), 32'(vecs[v].exp_done));
            check("vec_err_pulses", 32'(err_total - e0), 32'(vecs[v].exp_err));
            check("vec_en_seen", 32'(en_total > n0), 32'(vecs[v].exp_en));
            check("vec_en_before_csb", 32'(en_last), 32'(vecs[v].exp_en));
            check("vec_en_after_csb", 32'(spi_sd_en_o), 0);
            check("vec_sd_after_csb", 32'(spi_sd_o), 0);
            check("vec_wr_count", 32'(wr_count_o), 32'(model_cnt));
        end
        bd_read(8'h10, d); check("bd_10", 32'(d), 32'h AA);
        bd_read(8'h11, d); check("bd_11", 32'(d), 32'h 55);
        bd_read(8'hFF, d); check("bd_FF", 32'(d), 32'h 11);
        bd_read(8'h00, d); check("bd_00_wrap", 32'(d), 32'h 22);

        // Abort mid-byte: the partial byte must not be committed
        d0 = done_total;
        cs_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h3C, 8, rx);
        spi_bits(8'h99, 5, rx);
        cs_end();
        model_mem[8'h20] = 8'h3C; model_cnt++;
        bd_read(8'h20, d); check("abort_bd_20", 32'(d), 32'h 3C);
        bd_read(8'h21, d); check("abort_bd_21", 32'(d), 32'h 00);
        check("abort_wr_count", 32'(wr_count_o), 32'(model_cnt));
        check("abort_done", 32'(done_total - d0), 1);

        // CSB rise before the command byte completes: no pulses
        d0 = done_total; e0 = err_total;
        cs_start();
        wclk(2);
        check("busy_in_txn", 32'(busy_o), 1);
        spi_bits(8'h03, 3, rx);
        cs_end();
        check("short_busy", 32'(busy_o), 0);
        check("short_done", 32'(done_total - d0), 0);
        check("short_err", 32'(err_total - e0), 0);

        // Reset asserted mid-byte
        cs_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h30, 8, rx);
        spi_bits(8'hFF, 4, rx);
        rst_n = 1'b0;
        wclk(2);
        check("mrst_sd_o", 32'(spi_sd_o), 0);
        check("mrst_sd_en", 32'(spi_sd_en_o), 0);
        check("mrst_busy", 32'(busy_o), 0);
        check("mrst_wr_count", 32'(wr_count_o), 0);
        bd_read(8'h10, d); check("mrst_bd_10", 32'(d), 0);
        bd_read(8'h20, d); check("mrst_bd_20", 32'(d), 0);
        sck = 1'b0; csb = 1'b1;
        wclk(4);
        rst_n = 1'b1;
        wclk(6);
        model_clear();
        txn(8'h02, 8'h40, 1, 24'h5A0000, 24'h0);
        bd_read(8'h40, d); check("post_rst_bd_40", 32'(d), 32'h 5A);
        check("post_rst_wr_count", 32'(wr_count_o), 1);
        txn(8'h03, 8'h40, 1, 24'h0, 24'h5A0000);

        // Random write/read bursts of two bytes, 32 transactions = 64 bytes
        for (int k = 0; k < 32; k++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                b0 = 8'($urandom_range(0, 255));
                b1 = 8'($urandom_range(0, 255));
                txn(8'h02, a, 2, {b0, b1, 8'h00}, 24'h0);
            end else begin
                txn(8'h03, a, 2, 24'h0, {model_mem[a], model_mem[8'(a + 8'd1)], 8'h00});
            end
        end
        check("rand_wr_count", 32'(wr_count_o), 32'(model_cnt));
        for (int i = 0; i < 256; i++) begin
            bd_read(8'(i), d);
            check("rand_bd", 32'(d), 32'(model_mem[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
